// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period and high time of a clk-synchronous divided clock,
// checks the period against an expected ratio and reports lock and stuck conditions.
module div_clk_monitor #(
   parameter int CNT_W      = 8,
   parameter int EXP_PERIOD = 3,
   parameter int TOL        = 0,
   parameter int LOCK_CNT   = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_div_in,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high_time,
   output logic             o_meas_valid,
   output logic             o_period_ok,
   output logic             o_locked,
   output logic             o_stuck
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_MEAS  = 2'd2
   } state_t;

   localparam int SW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
   // Lower bound clamps at zero when the tolerance exceeds the expected period.
   localparam logic [CNT_W:0]   LO_BOUND  = (EXP_PERIOD > TOL) ? (CNT_W+1)'(EXP_PERIOD - TOL)
                                                               : (CNT_W+1)'(0);
   localparam logic [CNT_W:0]   HI_BOUND  = (CNT_W+1)'(EXP_PERIOD + TOL);
   localparam logic [SW-1:0]    LOCK_V    = SW'(LOCK_CNT);
   localparam logic [SW-1:0]    SW_ONE    = SW'(1);
   localparam logic [SW-1:0]    SW_ZERO   = {SW{1'b0}};

   state_t           r_state, w_state_nxt;
   logic             r_div_d;
   logic [CNT_W-1:0] r_per_cnt, w_per_nxt, w_per_inc;
   logic [CNT_W-1:0] r_high_cnt, w_high_nxt, w_high_inc;
   logic [SW-1:0]    r_streak, w_streak_nxt, w_streak_inc;
   logic [CNT_W-1:0] r_period, w_period_nxt;
   logic [CNT_W-1:0] r_high_time, w_high_time_nxt;
   logic             r_meas_valid, w_valid_nxt;
   logic             r_period_ok, w_ok_nxt;
   logic             r_locked, w_locked_nxt;
   logic             r_stuck, w_stuck_nxt;
   logic             w_rise, w_timeout, w_in_tol;

   // Next-state and next-value logic; in ALIGN the period counter doubles as the wait counter.
   always_comb begin
      w_rise          = i_div_in & ~r_div_d;
      w_per_inc       = (r_per_cnt == CNT_MAX) ? r_per_cnt : r_per_cnt + CNT_ONE;
      w_high_inc      = (r_high_cnt == CNT_MAX) ? r_high_cnt : r_high_cnt + CNT_ONE;
      w_streak_inc    = (r_streak >= LOCK_V) ? LOCK_V : r_streak + SW_ONE;
      w_timeout       = (r_per_cnt >= TIMEOUT_V);
      w_in_tol        = ({1'b0, r_per_cnt} >= LO_BOUND) && ({1'b0, r_per_cnt} <= HI_BOUND);
      w_state_nxt     = r_state;
      w_per_nxt       = r_per_cnt;
      w_high_nxt      = r_high_cnt;
      w_streak_nxt    = r_streak;
      w_period_nxt    = r_period;
      w_high_time_nxt = r_high_time;
      w_valid_nxt     = 1'b0;
      w_ok_nxt        = r_period_ok;
      w_locked_nxt    = r_locked;
      w_stuck_nxt     = 1'b0;
      if (!i_en) begin
         w_state_nxt  = ST_IDLE;
         w_per_nxt    = CNT_ZERO;
         w_high_nxt   = CNT_ZERO;
         w_streak_nxt = SW_ZERO;
         w_locked_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_ALIGN;
               w_per_nxt   = CNT_ZERO;
               w_high_nxt  = CNT_ZERO;
            end
            ST_ALIGN: begin
               if (w_rise) begin
                  w_state_nxt = ST_MEAS;
                  w_per_nxt   = CNT_ONE;
                  w_high_nxt  = CNT_ONE;
               end else if (w_timeout) begin
                  w_stuck_nxt  = 1'b1;
                  w_streak_nxt = SW_ZERO;
                  w_locked_nxt = 1'b0;
                  w_per_nxt    = CNT_ZERO;
               end else begin
                  w_per_nxt    = w_per_inc;
               end
            end
            ST_MEAS: begin
               if (w_rise) begin
                  w_period_nxt    = r_per_cnt;
                  w_high_time_nxt = r_high_cnt;
                  w_valid_nxt     = 1'b1;
                  w_ok_nxt        = w_in_tol;
                  w_per_nxt       = CNT_ONE;
                  w_high_nxt      = CNT_ONE;
                  if (w_in_tol) begin
                     w_streak_nxt = w_streak_inc;
                     w_locked_nxt = (w_streak_inc == LOCK_V);
                  end else begin
                     w_streak_nxt = SW_ZERO;
                     w_locked_nxt = 1'b0;
                  end
               end else if (w_timeout) begin
                  w_state_nxt  = ST_ALIGN;
                  w_stuck_nxt  = 1'b1;
                  w_streak_nxt = SW_ZERO;
                  w_locked_nxt = 1'b0;
                  w_per_nxt    = CNT_ZERO;
                  w_high_nxt   = CNT_ZERO;
               end else begin
                  w_per_nxt    = w_per_inc;
                  w_high_nxt   = i_div_in ? w_high_inc : r_high_cnt;
               end
            end
            default: begin
               w_state_nxt  = ST_IDLE;
               w_per_nxt    = CNT_ZERO;
               w_high_nxt   = CNT_ZERO;
               w_streak_nxt = SW_ZERO;
               w_locked_nxt = 1'b0;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Edge-detect delay, counters and registered outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_div_d      <= 1'b0;
         r_per_cnt    <= CNT_ZERO;
         r_high_cnt   <= CNT_ZERO;
         r_streak     <= SW_ZERO;
         r_period     <= CNT_ZERO;
         r_high_time  <= CNT_ZERO;
         r_meas_valid <= 1'b0;
         r_period_ok  <= 1'b0;
         r_locked     <= 1'b0;
         r_stuck      <= 1'b0;
      end else begin
         r_div_d      <= i_div_in;
         r_per_cnt    <= w_per_nxt;
         r_high_cnt   <= w_high_nxt;
         r_streak     <= w_streak_nxt;
         r_period     <= w_period_nxt;
         r_high_time  <= w_high_time_nxt;
         r_meas_valid <= w_valid_nxt;
         r_period_ok  <= w_ok_nxt;
         r_locked     <= w_locked_nxt;
         r_stuck      <= w_stuck_nxt;
      end
   end

   assign o_period     = r_period;
   assign o_high_time  = r_high_time;
   assign o_meas_valid = r_meas_valid;
   assign o_period_ok  = r_period_ok;
   assign o_locked     = r_locked;
   assign o_stuck      = r_stuck;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Scoreboard bench: three monitor configurations share one div_in stream; a timestamp and
// history based reference model queues expected events, a negedge monitor pops and compares.
module tb_div_clk_monitor;

   localparam int NI = 3;
   localparam int P_CNT_W [NI] = '{8, 8, 4};
   localparam int P_EXP   [NI] = '{3, 3, 3};
   localparam int P_TOL   [NI] = '{0, 1, 0};
   localparam int P_LOCK  [NI] = '{4, 4, 4};
   localparam int P_TO    [NI] = '{10, 255, 15};
   localparam int M_IDLE = 0, M_ALIGN = 1, M_MEAS = 2;

   typedef struct {
      bit is_meas;
      int per;
      int high;
      bit ok;
      bit lk;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n, en, div_in;
   logic [7:0] per_a, hi_a, per_b, hi_b;
   logic [3:0] per_c, hi_c;
   logic [NI-1:0] mv, ok, lk, st;
   logic [7:0] per_o [NI];
   logic [7:0] hi_o  [NI];

   int  n_chk = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  mode [NI];
   bit  prev [NI];
   int  align_entry [NI];
   int  streak [NI];
   bit  hist [NI][$];
   ev_t exp_q [NI][$];
   int  e_per [NI], e_high [NI];
   bit  e_ok [NI], e_lk [NI];

   div_clk_monitor #(.CNT_W(8), .EXP_PERIOD(3), .TOL(0), .LOCK_CNT(4), .TIMEOUT(10)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div_in(div_in),
      .o_period(per_a), .o_high_time(hi_a), .o_meas_valid(mv[0]),
      .o_period_ok(ok[0]), .o_locked(lk[0]), .o_stuck(st[0]));

   div_clk_monitor #(.CNT_W(8), .EXP_PERIOD(3), .TOL(1), .LOCK_CNT(4), .TIMEOUT(255)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div_in(div_in),
      .o_period(per_b), .o_high_time(hi_b), .o_meas_valid(mv[1]),
      .o_period_ok(ok[1]), .o_locked(lk[1]), .o_stuck(st[1]));

   div_clk_monitor #(.CNT_W(4), .EXP_PERIOD(3), .TOL(0), .LOCK_CNT(4), .TIMEOUT(15)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div_in(div_in),
      .o_period(per_c), .o_high_time(hi_c), .o_meas_valid(mv[2]),
      .o_period_ok(ok[2]), .o_locked(lk[2]), .o_stuck(st[2]));

   assign per_o[0] = per_a;
   assign per_o[1] = per_b;
   assign per_o[2] = {4'b0000, per_c};
   assign hi_o[0]  = hi_a;
   assign hi_o[1]  = hi_b;
   assign hi_o[2]  = {4'b0000, hi_c};

   initial forever #5 clk = ~clk;

   // Reference model step for configuration k, from the inputs sampled at this edge.
   task automatic model_step(input int k);
      bit  r;
      int  cap, lo, hi, ones;
      ev_t ev;
      r   = div_in && !prev[k];
      cap = (1 << P_CNT_W[k]) - 1;
      lo  = (P_EXP[k] > P_TOL[k]) ? P_EXP[k] - P_TOL[k] : 0;
      hi  = P_EXP[k] + P_TOL[k];
      if (!rst_n) begin
         mode[k] = M_IDLE; prev[k] = 1'b0; streak[k] = 0; hist[k].delete();
         e_per[k] = 0; e_high[k] = 0; e_ok[k] = 1'b0; e_lk[k] = 1'b0;
      end else begin
         if (!en) begin
            mode[k] = M_IDLE; streak[k] = 0; e_lk[k] = 1'b0; hist[k].delete();
         end else if (mode[k] == M_IDLE) begin
            mode[k] = M_ALIGN; align_entry[k] = cyc + 1;
         end else if (mode[k] == M_ALIGN) begin
            if (r) begin
               mode[k] = M_MEAS; hist[k].delete(); hist[k].push_back(1'b1);
            end else if (cyc - align_entry[k] >= P_TO[k]) begin
               ev = '{1'b0, 0, 0, 1'b0, 1'b0};
               exp_q[k].push_back(ev);
               streak[k] = 0; e_lk[k] = 1'b0; align_entry[k] = cyc + 1;
            end
         end else begin
            if (r) begin
               ones = 0;
               foreach (hist[k][i]) ones += int'(hist[k][i]);
               ev.is_meas = 1'b1;
               ev.per  = (hist[k].size() > cap) ? cap : hist[k].size();
               ev.high = (ones > cap) ? cap : ones;
               ev.ok   = (ev.per >= lo) && (ev.per <= hi);
               if (ev.ok) streak[k] = (streak[k] < P_LOCK[k]) ? streak[k] + 1 : P_LOCK[k];
               else       streak[k] = 0;
               ev.lk = (streak[k] == P_LOCK[k]);
               e_per[k] = ev.per; e_high[k] = ev.high; e_ok[k] = ev.ok; e_lk[k] = ev.lk;
               exp_q[k].push_back(ev);
               hist[k].delete(); hist[k].push_back(1'b1);
            end else if (hist[k].size() >= P_TO[k]) begin
               ev = '{1'b0, 0, 0, 1'b0, 1'b0};
               exp_q[k].push_back(ev);
               streak[k] = 0; e_lk[k] = 1'b0; mode[k] = M_ALIGN; align_entry[k] = cyc + 1;
               hist[k].delete();
            end else begin
               hist[k].push_back(div_in);
            end
         end
         prev[k] = div_in;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         for (int k = 0; k < NI; k++) model_step(k);
         cyc++;
      end
   end

   // Monitor: pops an expected event whenever the DUT pulses, and checks held outputs.
   task automatic mon_check(input int k);
      bit  got;
      ev_t ev;
      got = mv[k] | st[k];
      if (got || exp_q[k].size() != 0) begin
         n_chk++;
         if (!got) begin
            n_fail++;
            $display("FAIL event_missing[%0d] cyc=%0d got no pulse, required %s", k, cyc,
                     exp_q[k][0].is_meas ? "meas_valid" : "stuck");
            void'(exp_q[k].pop_front());
         end else if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL event_unexpected[%0d] cyc=%0d got mv=%0b st=%0b, required none",
                     k, cyc, mv[k], st[k]);
         end else begin
            ev = exp_q[k].pop_front();
            if (mv[k] != ev.is_meas || st[k] != !ev.is_meas ||
                (ev.is_meas && (int'(per_o[k]) != ev.per || int'(hi_o[k]) != ev.high ||
                                ok[k] != ev.ok || lk[k] != ev.lk))) begin
               n_fail++;
               $display("FAIL event[%0d] cyc=%0d got mv=%0b st=%0b per=%0d high=%0d ok=%0b lk=%0b, required mv=%0b st=%0b per=%0d high=%0d ok=%0b lk=%0b",
                        k, cyc, mv[k], st[k], per_o[k], hi_o[k], ok[k], lk[k],
                        ev.is_meas, !ev.is_meas, ev.per, ev.high, ev.ok, ev.lk);
            end
         end
      end
      n_chk++;
      if (int'(per_o[k]) != e_per[k] || int'(hi_o[k]) != e_high[k] ||
          ok[k] != e_ok[k] || lk[k] != e_lk[k]) begin
         n_fail++;
         $display("FAIL held[%0d] cyc=%0d got per=%0d high=%0d ok=%0b lk=%0b, required per=%0d high=%0d ok=%0b lk=%0b",
                  k, cyc, per_o[k], hi_o[k], ok[k], lk[k], e_per[k], e_high[k], e_ok[k], e_lk[k]);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) mon_check(k);
      end
   end

   task automatic drive(input bit d);
      div_in = d;
      @(negedge clk);
   endtask

   task automatic pattern(input int h, input int l, input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < h; i++) drive(1'b1);
         for (int i = 0; i < l; i++) drive(1'b0);
      end
   endtask

   initial begin
      int sel, a, b, c;
      rst_n = 1'b0; en = 1'b0; div_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; en = 1'b1;
      drive(1'b0); drive(1'b0);
      pattern(2, 1, 8);            // 1,1,0: lock on 4th measurement
      pattern(1, 2, 4);            // 1,0,0
      pattern(2, 2, 4);            // period 4: lock drops unless TOL=1
      pattern(2, 1, 6);
      pattern(14, 1, 1);           // stuck high in MEAS
      pattern(2, 1, 6);            // relock after 1+4 rises
      pattern(1, 9, 3);            // rise coincides with TIMEOUT=10
      pattern(2, 1, 2);
      en = 1'b0; drive(1'b1); drive(1'b0); en = 1'b1;
      pattern(2, 1, 6);
      drive(1'b1);
      rst_n = 1'b0; drive(1'b1); rst_n = 1'b1;
      drive(1'b0);
      pattern(2, 1, 6);
      pattern(1, 19, 3);           // period 20: saturation/timeout paths
      for (int s = 0; s < 120; s++) begin
         sel = int'($urandom_range(0, 9));
         a   = int'($urandom_range(1, 3));
         b   = int'($urandom_range(1, 3));
         c   = int'($urandom_range(1, 4));
         if (sel == 0) begin
            en = 1'b0; drive(1'($urandom_range(0, 1))); en = 1'b1;
         end else if (sel == 1) begin
            rst_n = 1'b0; drive(1'b0); rst_n = 1'b1;
         end else if (sel == 2) begin
            pattern(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1);
         end else begin
            pattern(a, b, c);
         end
      end
      drive(1'b0); drive(1'b0); drive(1'b0);
      for (int k = 0; k < NI; k++) begin
         n_chk++;
         if (exp_q[k].size() != 0) begin
            n_fail++;
            $display("FAIL drain[%0d] got %0d pending events, required 0", k, exp_q[k].size());
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
